// File: rtl/stage_ctrl_pkg.sv
// Shared control-plane constants: sequence state codes, stage indices and
// controller state encodings used by stage_ctrl and the datapath enables.
package stage_ctrl_pkg;

  localparam int STATE_LEN  = 4;
  localparam int STAGE_NUM  = 8;
  localparam int CSTATE_LEN = 3;

  // Sequence state codes driven by state_machine on q
  localparam logic [STATE_LEN-1:0] IDLE = 4'd0;
  localparam logic [STATE_LEN-1:0] RECV = 4'd1;
  localparam logic [STATE_LEN-1:0] EMB  = 4'd2;
  localparam logic [STATE_LEN-1:0] MIX1 = 4'd3;
  localparam logic [STATE_LEN-1:0] MIX2 = 4'd4;
  localparam logic [STATE_LEN-1:0] MIX3 = 4'd5;
  localparam logic [STATE_LEN-1:0] DENS = 4'd6;
  localparam logic [STATE_LEN-1:0] COMP = 4'd7;
  localparam logic [STATE_LEN-1:0] SEND = 4'd8;
  localparam logic [STATE_LEN-1:0] FIN  = 4'd9;

  // Stage indices into the start/done vectors
  localparam int STG_RECV = 0;
  localparam int STG_EMB  = 1;
  localparam int STG_MIX1 = 2;
  localparam int STG_MIX2 = 3;
  localparam int STG_MIX3 = 4;
  localparam int STG_DENS = 5;
  localparam int STG_COMP = 6;
  localparam int STG_SEND = 7;

  typedef enum logic [CSTATE_LEN-1:0] {
    C_IDLE   = 3'd0,
    C_SETTLE = 3'd1,
    C_LAUNCH = 3'd2,
    C_WAIT   = 3'd3,
    C_DONE   = 3'd4,
    C_ERR    = 3'd5
  } cstate_t;

endpackage

// File: rtl/stage_decode.sv
// Maps a sequence state code to the one-hot stage it belongs to. valid is
// low for IDLE, FIN and unused codes so callers can treat them as no-stage.
module stage_decode
  import stage_ctrl_pkg::*;
(
  input  logic [STATE_LEN-1:0] state,
  output logic [STAGE_NUM-1:0] onehot,
  output logic                 valid
);

  // Decode the work states; everything else yields an empty one-hot
  always_comb begin
    onehot = '0;
    valid  = 1'b1;
    case (state)
      RECV:    onehot[STG_RECV] = 1'b1;
      EMB:     onehot[STG_EMB]  = 1'b1;
      MIX1:    onehot[STG_MIX1] = 1'b1;
      MIX2:    onehot[STG_MIX2] = 1'b1;
      MIX3:    onehot[STG_MIX3] = 1'b1;
      DENS:    onehot[STG_DENS] = 1'b1;
      COMP:    onehot[STG_COMP] = 1'b1;
      SEND:    onehot[STG_SEND] = 1'b1;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/stage_ctrl.sv
// Stage controller: launches the stage owning the current sequence state,
// waits for its done pulse, measures its latency and advances the sequence.
// Any unexpected state code, external state change or watchdog expiry parks
// the controller in C_ERR until the host clears it.
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 clr,
  input  logic [STATE_LEN-1:0] state,
  input  logic [STAGE_NUM-1:0] done,
  output logic                 run,
  output logic [STAGE_NUM-1:0] start,
  output logic                 busy,
  output logic                 fin,
  output logic                 err,
  output logic [CNT_W-1:0]     cyc_last
);

  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(TIMEOUT);

  cstate_t              cs, cs_nxt;
  logic [STAGE_NUM-1:0] idx_q, idx_nxt;
  logic [STATE_LEN-1:0] st_q, st_nxt;
  logic [CNT_W-1:0]     cnt_q, cnt_nxt;
  logic [CNT_W:0]       cnt_plus;
  logic [CNT_W-1:0]     cyc_nxt;
  logic                 run_nxt;
  logic [STAGE_NUM-1:0] start_nxt;
  logic                 busy_nxt, fin_nxt, err_nxt;
  logic [STAGE_NUM-1:0] dec_onehot;
  logic                 dec_valid;

  stage_decode u_decode (
    .state  (state),
    .onehot (dec_onehot),
    .valid  (dec_valid)
  );

  // One extra bit so the comparison against TIMEOUT cannot wrap
  assign cnt_plus = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and next-output logic; outputs are derived here and registered
  always_comb begin
    cs_nxt    = cs;
    idx_nxt   = idx_q;
    st_nxt    = st_q;
    cnt_nxt   = cnt_q;
    cyc_nxt   = cyc_last;
    run_nxt   = 1'b0;
    start_nxt = '0;
    case (cs)
      C_IDLE: begin
        if (go) begin
          if (state == IDLE) begin
            run_nxt = 1'b1;
            cs_nxt  = C_SETTLE;
          end else begin
            cs_nxt = C_ERR;
          end
        end
      end
      C_SETTLE: cs_nxt = C_LAUNCH;
      C_LAUNCH: begin
        if (state == FIN) begin
          cs_nxt = C_DONE;
        end else if (dec_valid) begin
          start_nxt = dec_onehot;
          idx_nxt   = dec_onehot;
          st_nxt    = state;
          cnt_nxt   = '0;
          cs_nxt    = C_WAIT;
        end else begin
          cs_nxt = C_ERR;
        end
      end
      C_WAIT: begin
        cnt_nxt = cnt_plus[CNT_W-1:0];
        if (state != st_q) begin
          cs_nxt = C_ERR;
        end else if (|(done & idx_q)) begin
          cyc_nxt = cnt_plus[CNT_W-1:0];
          run_nxt = 1'b1;
          cs_nxt  = C_SETTLE;
        end else if (cnt_plus >= TIMEOUT_V) begin
          cs_nxt = C_ERR;
        end
      end
      C_DONE, C_ERR: begin
        if (clr) cs_nxt = C_IDLE;
      end
      default: cs_nxt = C_ERR;
    endcase
    busy_nxt = !(cs_nxt inside {C_IDLE, C_DONE, C_ERR});
    fin_nxt  = (cs_nxt == C_DONE);
    err_nxt  = (cs_nxt == C_ERR);
  end

  // Controller state, stage bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs       <= C_IDLE;
      idx_q    <= '0;
      st_q     <= IDLE;
      cnt_q    <= '0;
      cyc_last <= '0;
      run      <= 1'b0;
      start    <= '0;
      busy     <= 1'b0;
      fin      <= 1'b0;
      err      <= 1'b0;
    end else begin
      cs       <= cs_nxt;
      idx_q    <= idx_nxt;
      st_q     <= st_nxt;
      cnt_q    <= cnt_nxt;
      cyc_last <= cyc_nxt;
      run      <= run_nxt;
      start    <= start_nxt;
      busy     <= busy_nxt;
      fin      <= fin_nxt;
      err      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// Scoreboard bench for stage_ctrl: a small state_machine model and a stage
// responder surround the DUT; expected run/start/fin/err events with their
// edge numbers are queued when a scenario is launched and a negedge monitor
// pops and compares them as the DUT produces them.
module tb_stage_ctrl;
  import stage_ctrl_pkg::*;

  localparam int TMO     = 20;
  localparam int K_RUN   = 0;
  localparam int K_START = 1;
  localparam int K_FIN   = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int kind;
    int val;
    int at;
  } ev_t;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 go    = 1'b0;
  logic                 clr   = 1'b0;
  logic                 set   = 1'b0;
  logic [STATE_LEN-1:0] d     = IDLE;
  logic [STATE_LEN-1:0] sm_q  = IDLE;
  logic [STAGE_NUM-1:0] done  = '0;
  logic                 run;
  logic [STAGE_NUM-1:0] start;
  logic                 busy, fin, err;
  logic [15:0]          cyc_last;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_cyc = 0;
  ev_t  sb[$];
  int   lat[8];
  logic [7:0] hold_mask = '0;
  logic [7:0] inj_mask  = '0;
  int   inj_edge  = -100;
  int   pend_edge = -100;
  int   pend_idx  = 0;
  logic prev_fin = 1'b0;
  logic prev_err = 1'b0;

  stage_ctrl #(.TIMEOUT(TMO), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .clr      (clr),
    .state    (sm_q),
    .done     (done),
    .run      (run),
    .start    (start),
    .busy     (busy),
    .fin      (fin),
    .err      (err),
    .cyc_last (cyc_last)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter: after active edge k, cyc holds k
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state_machine: host set wins, otherwise run advances toward FIN
  always @(posedge clk) begin
    if (set) sm_q <= d;
    else if (run) sm_q <= (sm_q == FIN) ? FIN : sm_q + 4'd1;
  end

  // Stage responder: answers start[i] with done[i] lat[i] edges later
  always @(negedge clk) begin
    done = '0;
    if (!rst_n) begin
      pend_edge = -100;
    end else begin
      for (int i = 0; i < 8; i++)
        if (start[i] && !hold_mask[i]) begin
          pend_idx  = i;
          pend_edge = cyc + lat[i];
        end
      if (pend_edge == cyc + 1) begin
        done[pend_idx] = 1'b1;
        pend_edge = -100;
      end
      if (inj_edge == cyc + 1) done = done | inj_mask;
    end
  end

  function automatic string kname(input int k);
    case (k)
      K_RUN:   return "run";
      K_START: return "start";
      K_FIN:   return "fin";
      default: return "err";
    endcase
  endfunction

  function automatic int oh2idx(input logic [7:0] v);
    int r;
    r = 99;
    if ($countones(v) == 1)
      for (int i = 0; i < 8; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int start_edge(input int n, input int i);
    int s;
    s = n + 2;
    for (int j = 0; j < i; j++) s = s + lat[j] + 2;
    return s;
  endfunction

  task automatic expect_ev(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Scoreboard compare of one observed DUT event against the queue head
  task automatic check_output(input int kind, input int val);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_%s: got val=%0d at edge %0d, required no event",
               kname(kind), val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || e.at != cyc) begin
        failures++;
        $display("[TB] FAIL sb_%s: got %s val=%0d at edge %0d, required %s val=%0d at edge %0d",
                 kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.at);
      end
    end
  endtask

  task automatic check_level(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: turns DUT output activity into scoreboard comparisons
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_fin = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (run) check_output(K_RUN, int'(cyc_last));
      if (start != '0) check_output(K_START, oh2idx(start));
      if (fin && !prev_fin) check_output(K_FIN, 0);
      if (err && !prev_err) check_output(K_ERR, 0);
      prev_fin = fin;
      prev_err = err;
    end
  end

  // Queue the events of a run that completes stages 0..upto-1 (FIN if all 8)
  task automatic push_run(input int n, input int upto);
    int s;
    expect_ev(K_RUN, last_cyc, n);
    for (int i = 0; i < upto; i++) begin
      s = start_edge(n, i);
      expect_ev(K_START, i, s);
      expect_ev(K_RUN, lat[i], s + lat[i]);
      last_cyc = lat[i];
    end
    if (upto == 8) expect_ev(K_FIN, 0, start_edge(n, 8));
  endtask

  // Pulse go so it is sampled at edge n; mode 0 queues a run, mode 1 an error
  task automatic apply_stimulus(input int mode, input int upto, output int n);
    @(negedge clk);
    n = cyc + 1;
    if (mode == 0) push_run(n, upto);
    else expect_ev(K_ERR, 0, n);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_until(input int t);
    int g;
    g = 0;
    while (cyc < t && g < 2000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (sb.size() != 0 && g < 400) begin
      @(negedge clk);
      #1;
      g++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain: got %0d pending events, required 0", name, sb.size());
      sb.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_host();
    @(negedge clk);
    clr = 1'b1;
    set = 1'b1;
    d   = IDLE;
    @(negedge clk);
    clr = 1'b0;
    set = 1'b0;
    #1;
  endtask

  task automatic set_lat(input int v);
    for (int i = 0; i < 8; i++) lat[i] = v;
  endtask

  // Watchdog so the bench always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int n, s;
    set_lat(3);

    repeat (3) @(negedge clk);
    #1;
    check_level("rst_run", 32'(run), 0);
    check_level("rst_start", 32'(start), 0);
    check_level("rst_busy", 32'(busy), 0);
    check_level("rst_fin", 32'(fin), 0);
    check_level("rst_err", 32'(err), 0);
    check_level("rst_cyc_last", 32'(cyc_last), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] nominal run, latency 3");
    apply_stimulus(0, 8, n);
    wait_drain("nominal");
    check_level("nominal_busy", 32'(busy), 0);
    check_level("nominal_fin", 32'(fin), 1);
    check_level("nominal_q", 32'(sm_q), 32'(FIN));
    clear_host();
    check_level("clr_fin", 32'(fin), 0);

    $display("[TB] zero-wait run, latency 1");
    set_lat(1);
    apply_stimulus(0, 8, n);
    wait_drain("zerowait");
    check_level("zerowait_cyc_last", 32'(cyc_last), 1);
    clear_host();

    $display("[TB] timeout on MIX1");
    set_lat(3);
    hold_mask = 8'h04;
    apply_stimulus(0, 2, n);
    s = start_edge(n, 2);
    expect_ev(K_START, 2, s);
    expect_ev(K_ERR, 0, s + TMO);
    wait_drain("timeout");
    check_level("timeout_err", 32'(err), 1);
    check_level("timeout_busy", 32'(busy), 0);
    check_level("timeout_cyc_last", 32'(cyc_last), 3);
    hold_mask = '0;
    clear_host();
    check_level("timeout_clr_err", 32'(err), 0);
    set_lat(2);
    apply_stimulus(0, 8, n);
    wait_drain("after_timeout");
    clear_host();

    $display("[TB] wrong done while MIX1 active");
    set_lat(3);
    lat[2] = 8;
    inj_mask = 8'h20;
    apply_stimulus(0, 8, n);
    inj_edge = start_edge(n, 2) + 4;
    wait_drain("wrongdone");
    inj_edge = -100;
    check_level("wrongdone_fin", 32'(fin), 1);
    clear_host();

    $display("[TB] external set during EMB wait");
    set_lat(3);
    hold_mask = 8'h02;
    apply_stimulus(0, 1, n);
    s = start_edge(n, 1);
    expect_ev(K_START, 1, s);
    expect_ev(K_ERR, 0, s + 2);
    wait_until(s);
    set = 1'b1;
    d = DENS;
    @(negedge clk);
    set = 1'b0;
    wait_drain("extset");
    check_level("extset_err", 32'(err), 1);
    hold_mask = '0;
    clear_host();

    $display("[TB] done and state change on the same edge");
    lat[1] = 4;
    apply_stimulus(0, 1, n);
    s = start_edge(n, 1);
    expect_ev(K_START, 1, s);
    expect_ev(K_ERR, 0, s + 4);
    wait_until(s + 2);
    set = 1'b1;
    d = DENS;
    @(negedge clk);
    set = 1'b0;
    wait_drain("samecycle");
    check_level("samecycle_err", 32'(err), 1);
    clear_host();
    lat[1] = 3;

    $display("[TB] async reset while start is high");
    apply_stimulus(0, 0, n);
    expect_ev(K_START, 0, n + 2);
    wait_until(n + 2);
    #2 rst_n = 1'b0;
    #1;
    check_level("arst_run", 32'(run), 0);
    check_level("arst_start", 32'(start), 0);
    check_level("arst_busy", 32'(busy), 0);
    check_level("arst_fin", 32'(fin), 0);
    check_level("arst_err", 32'(err), 0);
    check_level("arst_cyc_last", 32'(cyc_last), 0);
    last_cyc = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    check_level("arst_q", 32'(sm_q), 32'(RECV));
    apply_stimulus(1, 0, n);
    wait_drain("go_not_idle");
    check_level("go_not_idle_err", 32'(err), 1);
    clear_host();

    $display("[TB] async reset while run is high");
    apply_stimulus(0, 0, n);
    wait_until(n);
    #2 rst_n = 1'b0;
    #1;
    check_level("arst2_run", 32'(run), 0);
    check_level("arst2_busy", 32'(busy), 0);
    last_cyc = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    set_lat(2);
    apply_stimulus(0, 8, n);
    wait_drain("final");
    check_level("final_fin", 32'(fin), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
